// File: rtl/preg_free_list_ctrl.sv
// Physical-register free list: circular FIFO of free tags, 2 allocs + 2 releases per cycle, self-filled after reset.
// Optional sticky fault flag on err under FL_ERR_CHECK_EN; otherwise err is tied low.
module preg_free_list_ctrl #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_AREGS = 32,
    parameter int PREG_W    = 6,
    localparam int DEPTH    = NUM_PREGS - NUM_AREGS,
    localparam int CNT_W    = PREG_W + 1,
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        alloc_req,
    output logic              alloc_gnt,
    output logic [PREG_W-1:0] alloc_preg_0,
    output logic [PREG_W-1:0] alloc_preg_1,
    input  logic [1:0]        rel_valid,
    input  logic [PREG_W-1:0] rel_preg_0,
    input  logic [PREG_W-1:0] rel_preg_1,
    output logic [CNT_W-1:0]  free_count,
    output logic              init_done,
    output logic              err
);
    typedef enum logic {FILL, READY} state_t;

    state_t            state, state_nxt;
    logic [PREG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head, tail, fill_ptr;
    logic [PTR_W-1:0]  head_p1, tail_p1;
    logic [CNT_W-1:0]  cnt, room;
    logic [1:0]        n_req, n_pop, n_rel, n_push, n_ins;
    logic [PREG_W-1:0] rel_first, rel_second;
    logic              wr_en0, wr_en1;
    logic [PREG_W-1:0] wr_dat0, wr_dat1;
    logic              is_ready;

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [1:0] n);
        logic [PTR_W:0] s;
        s = {1'b0, p} + {{(PTR_W-1){1'b0}}, n};
        if (s >= (PTR_W+1)'(DEPTH))
            s = s - (PTR_W+1)'(DEPTH);
        return s[PTR_W-1:0];
    endfunction

    assign is_ready     = (state == READY);
    assign init_done    = is_ready;
    assign free_count   = cnt;
    assign n_req        = {1'b0, alloc_req[0]} + {1'b0, alloc_req[1]};
    assign alloc_gnt    = is_ready && (cnt >= CNT_W'(n_req));
    assign n_pop        = alloc_gnt ? n_req : 2'd0;
    assign head_p1      = ptr_add(head, 2'd1);
    assign tail_p1      = ptr_add(tail, 2'd1);
    assign alloc_preg_0 = mem[head];
    assign alloc_preg_1 = alloc_req[0] ? mem[head_p1] : mem[head];

    // Releases compact into slot order; with room for only one, the earlier slot wins.
    assign n_rel      = {1'b0, rel_valid[0]} + {1'b0, rel_valid[1]};
    assign rel_first  = rel_valid[0] ? rel_preg_0 : rel_preg_1;
    assign rel_second = rel_preg_1;
    assign room       = CNT_W'(DEPTH) - (cnt - CNT_W'(n_pop));
    assign n_push     = (room >= CNT_W'(n_rel)) ? n_rel : room[1:0];

    always_comb begin
        wr_en0  = 1'b0;
        wr_en1  = 1'b0;
        wr_dat0 = rel_first;
        wr_dat1 = rel_second;
        n_ins   = 2'd0;
        if (!is_ready) begin
            wr_en0  = 1'b1;
            wr_en1  = 1'b1;
            wr_dat0 = PREG_W'(NUM_AREGS) + PREG_W'(fill_ptr);
            wr_dat1 = PREG_W'(NUM_AREGS) + PREG_W'(fill_ptr) + PREG_W'(1);
            n_ins   = 2'd2;
        end else begin
            wr_en0 = (n_push != 2'd0);
            wr_en1 = (n_push == 2'd2);
            n_ins  = n_push;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == FILL && fill_ptr == PTR_W'(DEPTH - 2))
            state_nxt = READY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FILL;
            head     <= '0;
            tail     <= '0;
            fill_ptr <= '0;
            cnt      <= '0;
        end else begin
            state <= state_nxt;
            head  <= ptr_add(head, n_pop);
            tail  <= ptr_add(tail, n_ins);
            cnt   <= cnt + CNT_W'(n_ins) - CNT_W'(n_pop);
            if (!is_ready)
                fill_ptr <= fill_ptr + PTR_W'(2);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (wr_en0)
                mem[tail] <= wr_dat0;
            if (wr_en1)
                mem[tail_p1] <= wr_dat1;
        end
    end

`ifdef FL_ERR_CHECK_EN
    logic err_q, err_set;
    assign err_set = (!is_ready && (rel_valid != 2'b00))
                   || (is_ready && (n_push < n_rel))
                   || (rel_valid[0] && ({1'b0, rel_preg_0} >= CNT_W'(NUM_PREGS)))
                   || (rel_valid[1] && ({1'b0, rel_preg_1} >= CNT_W'(NUM_PREGS)))
                   || ((rel_valid == 2'b11) && (rel_preg_0 == rel_preg_1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if (err_set)
            err_q <= 1'b1;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule
